b13_serial_rx: RTL and testbench

//  Receiver for the strobed serial stream produced by the b13 transmitter's data_out output.

---
 rtl/b13_serial_rx.sv | 267 ++++++++++++++++++++++++++
 tb/tb_b13_serial_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/b13_serial_rx.sv
// ---------------------------------------------------------------------------
// b13_serial_rx
//
// Receiver for the strobed serial stream driven by the b13 transmitter's
// data_out. The line idles high. Every symbol is a single-clock strobe, and
// consecutive strobes are BIT_CYCLES clocks apart.
// Frame layout: start(0), 8 data bits MSB first, stop(1).
// Each byte is rebuilt and buffered for a downstream reader. dsr_o goes back
// to the transmitter as flow control.
//
// Build option:
//   B13_RX_FIFO_EN  undefined -> a single holding register is the buffer
//                   defined   -> a FIFO_DEPTH-entry circular FIFO is the buffer
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   rx_in_i      in   serial line
//   rd_en_i      in   pops the head byte while rx_valid_o=1
//   err_clr_i    in   clears the sticky overrun flag
//   rx_data_o    out  head byte of the buffer
//   rx_valid_o   out  buffer is non-empty
//   dsr_o        out  registered; 1 = buffer can accept a byte
//   frame_err_o  out  one-cycle pulse for each aborted frame
//   overrun_o    out  sticky; a complete byte was dropped
// ---------------------------------------------------------------------------
module b13_serial_rx #(
  parameter int BIT_CYCLES = 106,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in_i,
  input  logic       rd_en_i,
  input  logic       err_clr_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       dsr_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  // The counter only needs to reach BIT_CYCLES. It never wraps.
  localparam int               CNT_W   = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rxState_t;

  rxState_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             wrEn_q, wrEn_d;
  logic [7:0]       wrData_q, wrData_d;
  logic             frameErr_q, frameErr_d;
  logic             overrun_q, overrun_d;
  logic             dsr_q, dsr_d;

  // Buffer handshake, driven by whichever buffer variant is built.
  logic             popOk;
  logic             pushOk;
  logic             drop;

  // Frame state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      wrEn_q     <= 1'b0;
      wrData_q   <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      wrEn_q     <= wrEn_d;
      wrData_q   <= wrData_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Frame decoder.
  // While a frame is open, a symbol is sampled when the counter reaches
  // BIT_CYCLES. A low on any other edge is a spurious strobe: it aborts the
  // frame, and it is consumed here instead of being taken as a new start bit.
  // A completed byte is staged in wrData_q for one cycle. The buffer therefore
  // updates on the edge after the stop-bit sample.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    wrEn_d     = 1'b0;
    wrData_d   = wrData_q;
    frameErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_in_i) begin
          state_d  = DATA;
          cnt_d    = CNT_ONE;
          bitIdx_d = '0;
        end
      end
      DATA, STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = CNT_ONE;
          if (state_q == DATA) begin
            shift_d[3'd7 - bitIdx_q] = rx_in_i;
            bitIdx_d                 = bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            if (rx_in_i) begin
              wrEn_d   = 1'b1;
              wrData_d = shift_q;
            end else begin
              frameErr_d = 1'b1;
            end
          end
        end else if (!rx_in_i) begin
          frameErr_d = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
          shift_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef B13_RX_FIFO_EN
  // Circular FIFO. FIFO_DEPTH is a power of two, so the pointers wrap
  // naturally. The count keeps one extra bit so that full and empty can be
  // told apart.
  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full;

  assign full   = (count_q == DEPTH_C);
  assign popOk  = rd_en_i && (count_q != '0);
  assign pushOk = wrEn_q && (!full || popOk);
  assign drop   = wrEn_q && full && !popOk;

  // Occupancy after this edge's push and pop.
  always_comb begin
    count_d = count_q;
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers. The storage is cleared on reset so that the
  // head byte reads 0 after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (pushOk) begin
        mem_q[wrPtr_q] <= wrData_q;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (popOk) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign rx_data_o  = mem_q[rdPtr_q];
  assign rx_valid_o = (count_q != '0);
  assign dsr_d      = (count_d != DEPTH_C);
`else
  // Single holding register. While it holds a byte it is full, unless that
  // byte is popped on the same edge as the new write.
  logic [7:0] hold_q;
  logic       valid_q, valid_d;

  assign popOk  = rd_en_i && valid_q;
  assign pushOk = wrEn_q && (!valid_q || popOk);
  assign drop   = wrEn_q && valid_q && !popOk;

  // Valid flag after this edge's push and pop.
  always_comb begin
    valid_d = valid_q;
    if (popOk) begin
      valid_d = 1'b0;
    end
    if (pushOk) begin
      valid_d = 1'b1;
    end
  end

  // Holding register and its valid flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (pushOk) begin
        hold_q <= wrData_q;
      end
      valid_q <= valid_d;
    end
  end

  assign rx_data_o  = hold_q;
  assign rx_valid_o = valid_q;
  assign dsr_d      = !valid_d;
`endif

  // Overrun is sticky. A drop on the same edge as err_clr_i takes priority,
  // so the flag stays set.
  always_comb begin
    overrun_d = overrun_q;
    if (err_clr_i) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  // Status flags. dsr_q is computed from the post-edge occupancy, so it drops
  // on the same edge that fills the buffer. It reads 0 while reset is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
      dsr_q     <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      dsr_q     <= dsr_d;
    end
  end

  assign dsr_o       = dsr_q;
  assign frame_err_o = frameErr_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_b13_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_b13_serial_rx
//
// Self-checking bench for b13_serial_rx. It drives strobed frames onto the
// line and tracks the expected buffer contents in a byte queue. The queue
// capacity is 1 in the default build and FIFO_DEPTH when B13_RX_FIFO_EN is
// defined. The bench also tracks the expected sticky overrun flag.
// ---------------------------------------------------------------------------
module tb_b13_serial_rx;

  localparam int BIT_CYCLES = 106;
  localparam int FIFO_DEPTH = 4;
`ifdef B13_RX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       rxIn   = 1'b1;
  logic       rdEn   = 1'b0;
  logic       errClr = 1'b0;
  logic [7:0] rxData;
  logic       rxValid;
  logic       dsr;
  logic       frameErr;
  logic       overrun;

  int         checks   = 0;
  int         failures = 0;

  logic [7:0] modelQ[$];
  logic       modelOv = 1'b0;

  b13_serial_rx #(
    .BIT_CYCLES(BIT_CYCLES),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_in_i    (rxIn),
    .rd_en_i    (rdEn),
    .err_clr_i  (errClr),
    .rx_data_o  (rxData),
    .rx_valid_o (rxValid),
    .dsr_o      (dsr),
    .frame_err_o(frameErr),
    .overrun_o  (overrun)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with the queue model.
  task automatic checkState(input string tag, input logic expFrameErr);
    logic expValid;
    logic expDsr;
    expValid = (modelQ.size() != 0);
    expDsr   = (modelQ.size() < CAP);
    checkOutput({tag, ".valid"}, {7'b0, rxValid}, {7'b0, expValid});
    if (expValid) begin
      checkOutput({tag, ".data"}, rxData, modelQ[0]);
    end
    checkOutput({tag, ".dsr"}, {7'b0, dsr}, {7'b0, expDsr});
    checkOutput({tag, ".overrun"}, {7'b0, overrun}, {7'b0, modelOv});
    checkOutput({tag, ".frameErr"}, {7'b0, frameErr}, {7'b0, expFrameErr});
  endtask

  // Check the reset values of all outputs.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".data"}, rxData, 8'h00);
    checkOutput({tag, ".valid"}, {7'b0, rxValid}, 8'h00);
    checkOutput({tag, ".dsr"}, {7'b0, dsr}, 8'h00);
    checkOutput({tag, ".frameErr"}, {7'b0, frameErr}, 8'h00);
    checkOutput({tag, ".overrun"}, {7'b0, overrun}, 8'h00);
  endtask

  // Drive the first nSym symbols of a frame (start, data MSB first, stop).
  // Each symbol is a one-clock strobe, and strobes are BIT_CYCLES clocks
  // apart. The task returns just after the edge that samples the last symbol.
  task automatic applyStimulus(input logic [7:0] b, input int nSym, input logic stopVal);
    logic [9:0] sym;
    sym = {1'b0, b, stopVal};
    for (int i = 0; i < nSym; i++) begin
      rxIn = sym[9 - i];
      tick();
      rxIn = 1'b1;
      if (i != nSym - 1) begin
        repeat (BIT_CYCLES - 1) tick();
      end
    end
  endtask

  // Call this just after a good stop sample. It checks that nothing has
  // changed yet, then applies the write edge, with optional read/clear on the
  // same edge.
  task automatic frameEnd(input logic [7:0] b, input logic withRead, input logic withClr);
    bit popOk;
    bit pushOk;
    checkState("preWrite", 1'b0);
    rdEn   = withRead;
    errClr = withClr;
    tick();
    rdEn   = 1'b0;
    errClr = 1'b0;
    popOk  = withRead && (modelQ.size() > 0);
    pushOk = (modelQ.size() < CAP) || popOk;
    if (withClr) modelOv = 1'b0;
    if (popOk) void'(modelQ.pop_front());
    if (pushOk) modelQ.push_back(b);
    else modelOv = 1'b1;
    checkState("write", 1'b0);
  endtask

  // Send a complete, clean frame and apply its write edge.
  task automatic sendByte(input logic [7:0] b, input logic withRead, input logic withClr);
    applyStimulus(b, 10, 1'b1);
    frameEnd(b, withRead, withClr);
  endtask

  // Pulse rd_en for one cycle. A pop while empty is ignored.
  task automatic popByte(input string tag);
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    if (modelQ.size() > 0) void'(modelQ.pop_front());
    checkState(tag, 1'b0);
  endtask

  // Pulse err_clr for one cycle.
  task automatic clearErr();
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    modelOv = 1'b0;
    checkState("errClr", 1'b0);
  endtask

  // Directed scenarios first, then randomized frames.
  initial begin
    logic [7:0] b;

    reset = 1'b1;
    repeat (3) tick();
    checkResetValues("reset");
    reset = 1'b0;
    tick();
    checkState("afterReset", 1'b0);

    // A first byte fills the buffer.
    sendByte(8'hA5, 1'b0, 1'b0);
    popByte("popA5");

    // Receive a byte, then read it back on the following cycle.
    repeat (5) tick();
    sendByte(8'h3C, 1'b0, 1'b0);
    popByte("pop3C");

    // A spurious low 50 clocks after the bit-3 strobe aborts the frame.
    applyStimulus(8'h5A, 5, 1'b1);
    repeat (49) tick();
    rxIn = 1'b0;
    tick();
    rxIn = 1'b1;
    checkState("spurious", 1'b1);
    tick();
    checkState("spuriousEnd", 1'b0);
    repeat (20) tick();
    sendByte(8'h81, 1'b0, 1'b0);
    popByte("pop81");

    // A low stop bit aborts the frame, and the byte is discarded.
    applyStimulus(8'h77, 10, 1'b0);
    checkState("badStop", 1'b1);
    tick();
    checkState("badStopEnd", 1'b0);

    // Two bytes with no read in between, then clear the overrun.
    sendByte(8'h11, 1'b0, 1'b0);
    repeat (7) tick();
    sendByte(8'h22, 1'b0, 1'b0);
    clearErr();
    while (modelQ.size() > 0) popByte("drain1");

    // Fill the buffer. An extra byte with err_clr on the same edge leaves
    // overrun set. A write while full, with a read on the same edge, succeeds.
    for (int k = 0; k < CAP; k++) sendByte(8'h40 + 8'(k), 1'b0, 1'b0);
    sendByte(8'h9E, 1'b0, 1'b1);
    sendByte(8'h6D, 1'b1, 1'b0);
    clearErr();
    while (modelQ.size() > 0) popByte("drain2");

    // Five bytes in a row, then pop everything and one more time while empty.
    for (int k = 1; k <= 5; k++) sendByte(8'(k), 1'b0, 1'b0);
    for (int k = 0; k <= CAP; k++) popByte("drain3");
    clearErr();

    // A write and a read on the same edge while empty: the write lands.
    sendByte(8'hE7, 1'b1, 1'b0);
    popByte("popE7");

    // Reset in the middle of bit 5 of a frame.
    applyStimulus(8'hC3, 6, 1'b1);
    repeat (30) tick();
    #2;
    reset = 1'b1;
    #1;
    modelQ.delete();
    modelOv = 1'b0;
    checkResetValues("midReset");
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    tick();
    checkState("afterMidReset", 1'b0);
    sendByte(8'hFF, 1'b0, 1'b0);
    popByte("popFF");

    // Randomized frames, with random reads, clears and gaps.
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(1, 30)) tick();
      sendByte(b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) popByte("randPop");
      if ($urandom_range(0, 4) == 0) clearErr();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
